// File: rtl/serial_byte_assembler.sv
// Serial-to-parallel word assembler: one bit per cycle in over valid/ready,
// WIDTH-bit words out over valid/ready, with short-frame detection and a delivered-word count.
module serial_byte_assembler #(
   parameter int       WIDTH     = 8,
   parameter bit       MSB_FIRST = 1'b1,
   parameter int       CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_bit,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             frame_err,
   output logic [CNT_W-1:0] word_count
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_valid;
   logic             r_frame_err;
   logic [CNT_W-1:0] r_word_count;

   state_t           w_state_nxt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [WIDTH-1:0] w_shift_nxt;
   logic [WIDTH-1:0] w_out_data_nxt;
   logic             w_out_valid_nxt;
   logic             w_frame_err_nxt;
   logic [WIDTH-1:0] w_shifted;
   logic             w_accept;
   logic             w_xfer;

   assign in_ready   = !r_out_valid || out_ready;
   assign w_accept   = in_valid && in_ready;
   assign w_xfer     = r_out_valid && out_ready;

   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign frame_err  = r_frame_err;
   assign word_count = r_word_count;

   // The earliest bit migrates toward the far end so it lands in [WIDTH-1] or [0] after WIDTH shifts.
   assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], in_bit}
                                : {in_bit, r_shift[WIDTH-1:1]};

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_shift_nxt     = r_shift;
      w_out_data_nxt  = r_out_data;
      w_out_valid_nxt = r_out_valid && !out_ready;
      w_frame_err_nxt = 1'b0;

      if (r_state == S_FULL && w_xfer) begin
         w_state_nxt = S_IDLE;
      end

      if (w_accept) begin
         if (r_cnt == LAST_IDX) begin
            w_out_data_nxt  = w_shifted;
            w_out_valid_nxt = 1'b1;
            w_cnt_nxt       = '0;
            w_state_nxt     = S_FULL;
         end else if (in_last) begin
            w_cnt_nxt       = '0;
            w_state_nxt     = S_IDLE;
            w_frame_err_nxt = 1'b1;
         end else begin
            w_shift_nxt     = w_shifted;
            w_cnt_nxt       = r_cnt + CW'(1);
            w_state_nxt     = S_SHIFT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_out_data   <= '0;
         r_out_valid  <= 1'b0;
         r_frame_err  <= 1'b0;
         r_word_count <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_out_data   <= w_out_data_nxt;
         r_out_valid  <= w_out_valid_nxt;
         r_frame_err  <= w_frame_err_nxt;
         if (w_xfer) begin
            r_word_count <= r_word_count + CNT_W'(1);
         end
      end
   end

   // Stale partial bits are fully shifted out before the next word completes, so no reset is needed.
   always_ff @(posedge clk) begin
      r_shift <= w_shift_nxt;
   end

endmodule

// File: tb/tb_serial_byte_assembler.sv
// Randomized and directed bench for serial_byte_assembler: three instances (MSB-first, LSB-first,
// 4-bit counter) share one input stream and are compared against a frame-level reference model.
module tb_serial_byte_assembler;

   logic       clk;
   logic       reset;
   logic       in_bit;
   logic       in_valid;
   logic       in_last;
   logic       out_ready;

   logic       rdy_m, rdy_l, rdy_c;
   logic [7:0] data_m, data_l, data_c;
   logic       vld_m, vld_l, vld_c;
   logic       err_m, err_l, err_c;
   logic [15:0] wc_m, wc_l;
   logic [3:0]  wc_c;

   serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(16)) dut_m (
      .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
      .in_ready(rdy_m), .out_data(data_m), .out_valid(vld_m), .out_ready(out_ready),
      .frame_err(err_m), .word_count(wc_m));

   serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(16)) dut_l (
      .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
      .in_ready(rdy_l), .out_data(data_l), .out_valid(vld_l), .out_ready(out_ready),
      .frame_err(err_l), .word_count(wc_l));

   serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(4)) dut_c (
      .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last),
      .in_ready(rdy_c), .out_data(data_c), .out_valid(vld_c), .out_ready(out_ready),
      .frame_err(err_c), .word_count(wc_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: bits of the frame in progress, the held word, and delivered-word count.
   bit         m_q[$];
   logic [7:0] m_word_m, m_word_l;
   logic       m_valid;
   logic       m_err;
   int         m_count;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] pack(input bit msb);
      logic [7:0] w;
      w = '0;
      for (int i = 0; i < 8; i++) begin
         if (msb) w[7-i] = m_q[i];
         else     w[i]   = m_q[i];
      end
      return w;
   endfunction

   task automatic step(input logic b, input logic v, input logic l, input logic r, input logic rst);
      logic exp_ready;
      logic accept;
      logic xfer;
      in_bit = b; in_valid = v; in_last = l; out_ready = r; reset = rst;
      #1;
      exp_ready = !m_valid || r;
      check("in_ready_m", 32'(rdy_m), 32'(exp_ready));
      check("in_ready_l", 32'(rdy_l), 32'(exp_ready));
      check("in_ready_c", 32'(rdy_c), 32'(exp_ready));
      @(posedge clk);
      if (rst) begin
         m_q.delete();
         m_valid  = 1'b0;
         m_err    = 1'b0;
         m_count  = 0;
         m_word_m = '0;
         m_word_l = '0;
      end else begin
         accept = v && exp_ready;
         xfer   = m_valid && r;
         m_err  = 1'b0;
         if (xfer) begin
            m_count++;
            m_valid = 1'b0;
         end
         if (accept) begin
            m_q.push_back(b);
            if (m_q.size() == 8) begin
               m_word_m = pack(1'b1);
               m_word_l = pack(1'b0);
               m_valid  = 1'b1;
               m_q.delete();
            end else if (l) begin
               m_q.delete();
               m_err = 1'b1;
            end
         end
      end
      @(negedge clk);
      check("out_valid_m", 32'(vld_m), 32'(m_valid));
      check("out_valid_l", 32'(vld_l), 32'(m_valid));
      check("frame_err_m", 32'(err_m), 32'(m_err));
      check("frame_err_l", 32'(err_l), 32'(m_err));
      check("out_data_m", 32'(data_m), 32'(m_word_m));
      check("out_data_l", 32'(data_l), 32'(m_word_l));
      check("out_data_c", 32'(data_c), 32'(m_word_m));
      check("word_count_m", 32'(wc_m), 32'(m_count % 65536));
      check("word_count_c", 32'(wc_c), 32'(m_count % 16));
   endtask

   // Send one word first-bit-first as data[7] down to data[0], optionally with random gaps.
   task automatic send_word(input logic [7:0] w, input logic r, input bit gaps);
      for (int i = 7; i >= 0; i--) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) step(1'($urandom), 1'b0, 1'b0, r, 1'b0);
         end
         step(w[i], 1'b1, 1'b0, r, 1'b0);
      end
   endtask

   initial begin
      logic [7:0] w;
      in_bit = 0; in_valid = 0; in_last = 0; out_ready = 0; reset = 1;
      m_valid = 0; m_err = 0; m_count = 0; m_word_m = '0; m_word_l = '0;
      @(negedge clk);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("reset_valid", 32'(vld_m), 32'd0);
      check("reset_count", 32'(wc_m), 32'd0);
      check("reset_data", 32'(data_m), 32'd0);

      // Basic assembly in both bit orders.
      send_word(8'hB2, 1'b1, 1'b0);
      check("basic_valid", 32'(vld_m), 32'd1);
      check("basic_msb", 32'(data_m), 32'hB2);
      check("basic_lsb", 32'(data_l), 32'h4D);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("basic_count", 32'(wc_m), 32'd1);

      // Backpressure, then handshake and new bit in the same cycle.
      send_word(8'hB2, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
      check("bp_hold", 32'(data_m), 32'hB2);
      check("bp_ready", 32'(rdy_m), 32'd0);
      w = 8'h5A;
      send_word(w, 1'b1, 1'b0);
      check("bp_next_word", 32'(data_m), 32'h5A);
      check("bp_count", 32'(wc_m), 32'd2);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // Short frame.
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      check("short_err", 32'(err_m), 32'd1);
      check("short_novalid", 32'(vld_m), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("short_err_pulse", 32'(err_m), 32'd0);
      send_word(8'hFF, 1'b1, 1'b0);
      check("after_short", 32'(data_m), 32'hFF);

      // Reset mid-word.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      check("rst_mid_valid", 32'(vld_m), 32'd0);
      check("rst_mid_count", 32'(wc_m), 32'd0);
      send_word(8'h01, 1'b1, 1'b0);
      check("rst_mid_word", 32'(data_m), 32'h01);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 800; i++) begin
         step(1'($urandom), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0),
              1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 99) == 0));
      end

      // Sixteen back-to-back words with gaps; 4-bit counter wraps to zero.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 16; k++) begin
         w = 8'($urandom);
         send_word(w, 1'b1, 1'b1);
         check("b2b_word", 32'(data_m), 32'(w));
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("b2b_count16", 32'(wc_m), 32'd16);
      check("b2b_wrap4", 32'(wc_c), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
